// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the MIPS hazard/forwarding controller:
// register-number type, forwarding-select encodings and the $0-aware compare.
package hazard_ctrl_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regNum_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // $0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic regMatch(input regNum_t a, input regNum_t b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow copy of the destination/control bits travelling through EX, MEM and WB.
// The E slot is zeroed on a flush; reset clears every slot and wins over a flush.
module hazard_shadow_pipe
    import hazard_ctrl_pkg::*;
(
    input  logic    Clk,
    input  logic    Reset,
    input  logic    FlushE,
    input  regNum_t RsD,
    input  regNum_t RtD,
    input  regNum_t WriteRegD,
    input  logic    RegWriteD,
    input  logic    MemtoRegD,
    output regNum_t RsE,
    output regNum_t RtE,
    output regNum_t WriteRegE,
    output logic    RegWriteE,
    output logic    MemtoRegE,
    output regNum_t WriteRegM,
    output logic    RegWriteM,
    output logic    MemtoRegM,
    output regNum_t WriteRegW,
    output logic    RegWriteW
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            RsE       <= '0;
            RtE       <= '0;
            WriteRegE <= '0;
            RegWriteE <= 1'b0;
            MemtoRegE <= 1'b0;
            WriteRegM <= '0;
            RegWriteM <= 1'b0;
            MemtoRegM <= 1'b0;
            WriteRegW <= '0;
            RegWriteW <= 1'b0;
        end else begin
            // NOTE: non-blocking, so W picks up the old M and M the old E on the same edge.
            WriteRegW <= WriteRegM;
            RegWriteW <= RegWriteM;
            WriteRegM <= WriteRegE;
            RegWriteM <= RegWriteE;
            MemtoRegM <= MemtoRegE;
            if (FlushE) begin
                RsE       <= '0;
                RtE       <= '0;
                WriteRegE <= '0;
                RegWriteE <= 1'b0;
                MemtoRegE <= 1'b0;
            end else begin
                RsE       <= RsD;
                RtE       <= RtD;
                WriteRegE <= WriteRegD;
                RegWriteE <= RegWriteD;
                MemtoRegE <= MemtoRegD;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline: stall/flush,
// EX and ID-branch forwarding selects, and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic [REG_W-1:0] RdD,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             RegDstD,
    input  logic             BeqD,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [CNT_W-1:0] StallCount
);

    regNum_t writeRegD;
    regNum_t rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic    regWriteE, memtoRegE, regWriteM, memtoRegM, regWriteW;
    logic    lwStall, branchStall, anyStall;

    assign writeRegD = RegDstD ? RdD : RtD;

    hazard_shadow_pipe uShadow (
        .Clk       (Clk),
        .Reset     (Reset),
        .FlushE    (anyStall),
        .RsD       (RsD),
        .RtD       (RtD),
        .WriteRegD (writeRegD),
        .RegWriteD (RegWriteD),
        .MemtoRegD (MemtoRegD),
        .RsE       (rsE),
        .RtE       (rtE),
        .WriteRegE (writeRegE),
        .RegWriteE (regWriteE),
        .MemtoRegE (memtoRegE),
        .WriteRegM (writeRegM),
        .RegWriteM (regWriteM),
        .MemtoRegM (memtoRegM),
        .WriteRegW (writeRegW),
        .RegWriteW (regWriteW)
    );

    assign lwStall = memtoRegE & (regMatch(rtE, RsD) | regMatch(rtE, RtD));

    // A branch compares in ID, so it waits for an ALU result still in EX
    // or a load result still in MEM.
    assign branchStall = BeqD &
        ((regWriteE & (regMatch(writeRegE, RsD) | regMatch(writeRegE, RtD))) |
         (memtoRegM & (regMatch(writeRegM, RsD) | regMatch(writeRegM, RtD))));

    assign anyStall = lwStall | branchStall;
    assign StallF   = anyStall;
    assign StallD   = anyStall;
    assign FlushE   = anyStall;

    assign ForwardAD = regWriteM & regMatch(writeRegM, RsD);
    assign ForwardBD = regWriteM & regMatch(writeRegM, RtD);

    // MEM is checked first: it holds the younger, more recent write.
    always_comb begin
        ForwardAE = FWD_RF;
        if (regWriteM && regMatch(writeRegM, rsE))
            ForwardAE = FWD_MEM;
        else if (regWriteW && regMatch(writeRegW, rsE))
            ForwardAE = FWD_WB;

        ForwardBE = FWD_RF;
        if (regWriteM && regMatch(writeRegM, rtE))
            ForwardBE = FWD_MEM;
        else if (regWriteW && regMatch(writeRegW, rtE))
            ForwardBE = FWD_WB;
    end

    always_ff @(posedge Clk) begin
        if (Reset)
            StallCount <= '0;
        else if (anyStall && (StallCount != '1))
            StallCount <= StallCount + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instruction sequences with scoreboarded
// expectations, plus a narrow-counter instance to reach saturation quickly.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [4:0] RsD, RtD, RdD;
    logic       RegWriteD, MemtoRegD, RegDstD, BeqD;

    logic        StallF, StallD, FlushE, ForwardAD, ForwardBD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] StallCount;

    logic        sStallF, sStallD, sFlushE, sForwardAD, sForwardBD;
    logic [1:0]  sForwardAE, sForwardBE;
    logic [3:0]  sStallCount;

    int nAsserts = 0;
    int nFail    = 0;
    int expCount = 0;

    typedef struct {
        string      tag;
        logic       stall;
        logic [1:0] ae;
        logic [1:0] be;
        logic       ad;
        logic       bd;
    } expect_t;

    expect_t sb[$];

    hazard_ctrl #(.CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .RegDstD(RegDstD), .BeqD(BeqD),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .StallCount(StallCount)
    );

    // Narrow counter so saturation is reachable within a short run.
    hazard_ctrl #(.CNT_W(4)) dutSmall (
        .Clk(Clk), .Reset(Reset), .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .RegDstD(RegDstD), .BeqD(BeqD),
        .StallF(sStallF), .StallD(sStallD), .FlushE(sFlushE),
        .ForwardAE(sForwardAE), .ForwardBE(sForwardBE),
        .ForwardAD(sForwardAD), .ForwardBD(sForwardBD), .StallCount(sStallCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nAsserts++;
        assert (obs === expv) else begin
            nFail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic setD(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic rw, input logic mtr, input logic rdst, input logic beq);
        RsD = rs; RtD = rt; RdD = rd;
        RegWriteD = rw; MemtoRegD = mtr; RegDstD = rdst; BeqD = beq;
    endtask

    task automatic nop();
        setD(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rType(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        setD(rs, rt, rd, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic lw(input logic [4:0] rt, input logic [4:0] base);
        setD(base, rt, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic beq(input logic [4:0] rs, input logic [4:0] rt);
        setD(rs, rt, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Inputs are already driven; push the expectation, compare once settled,
    // then advance one clock and account for the edge in the expected count.
    task automatic step(input string tag, input logic stall, input logic [1:0] ae,
                        input logic [1:0] be, input logic ad, input logic bd);
        expect_t e;
        int      expSmall;
        sb.push_back('{tag, stall, ae, be, ad, bd});
        #1;
        e = sb.pop_front();
        expSmall = (expCount > 15) ? 15 : expCount;
        chk({e.tag, ".StallF"},     32'(StallF),      32'(e.stall));
        chk({e.tag, ".StallD"},     32'(StallD),      32'(e.stall));
        chk({e.tag, ".FlushE"},     32'(FlushE),      32'(e.stall));
        chk({e.tag, ".ForwardAE"},  32'(ForwardAE),   32'(e.ae));
        chk({e.tag, ".ForwardBE"},  32'(ForwardBE),   32'(e.be));
        chk({e.tag, ".ForwardAD"},  32'(ForwardAD),   32'(e.ad));
        chk({e.tag, ".ForwardBD"},  32'(ForwardBD),   32'(e.bd));
        chk({e.tag, ".StallCount"}, 32'(StallCount),  32'(expCount));
        chk({e.tag, ".smallCount"}, 32'(sStallCount), 32'(expSmall));
        chk({e.tag, ".smallOuts"},
            32'({sStallF, sStallD, sFlushE, sForwardAE, sForwardBE, sForwardAD, sForwardBD}),
            32'({e.stall, e.stall, e.stall, e.ae, e.be, e.ad, e.bd}));
        @(posedge Clk);
        #2;
        if (Reset)
            expCount = 0;
        else if (e.stall && expCount < 65535)
            expCount++;
    endtask

    task automatic drain();
        nop();
        repeat (3) step("drain", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
    endtask

    initial begin
        Reset = 1'b1;
        nop();
        repeat (2) @(posedge Clk);
        #2;
        Reset = 1'b0;
        step("reset", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);

        // add $3,$1,$2 ; sub $4,$3,$5 -> MEM forward on A
        rType(5'd3, 5'd1, 5'd2); step("fm.add", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        rType(5'd4, 5'd3, 5'd5); step("fm.sub", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        nop();                   step("fm.fwd", 1'b0, FWD_MEM, FWD_RF, 1'b0, 1'b0);
        drain();

        // add ; nop ; sub -> WB forward on A
        rType(5'd3, 5'd1, 5'd2); step("fw.add", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        nop();                   step("fw.nop", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        rType(5'd4, 5'd3, 5'd5); step("fw.sub", 1'b0, FWD_RF, FWD_RF, 1'b1, 1'b0);
        nop();                   step("fw.fwd", 1'b0, FWD_WB, FWD_RF, 1'b0, 1'b0);
        drain();

        // add $3 ; add $3 ; sub $4,$3,$3 -> MEM wins over WB on both sources
        rType(5'd3, 5'd1, 5'd2); step("pr.add1", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        rType(5'd3, 5'd6, 5'd7); step("pr.add2", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        rType(5'd4, 5'd3, 5'd3); step("pr.sub",  1'b0, FWD_RF, FWD_RF, 1'b1, 1'b1);
        nop();                   step("pr.fwd",  1'b0, FWD_MEM, FWD_MEM, 1'b0, 1'b0);
        drain();

        // add $3 ; nop ; sub $4,$5,$3 -> WB forward on B
        rType(5'd3, 5'd1, 5'd2); step("fb.add", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        nop();                   step("fb.nop", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        rType(5'd4, 5'd5, 5'd3); step("fb.sub", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b1);
        nop();                   step("fb.fwd", 1'b0, FWD_RF, FWD_WB, 1'b0, 1'b0);
        drain();

        // lw $2,0($0) ; add $4,$2,$1 -> one stall cycle, then WB forward
        lw(5'd2, 5'd0);          step("lu.lw",    1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        rType(5'd4, 5'd2, 5'd1); step("lu.stall", 1'b1, FWD_RF, FWD_RF, 1'b0, 1'b0);
        step("lu.hold", 1'b0, FWD_RF, FWD_RF, 1'b1, 1'b0);
        nop();                   step("lu.fwd",   1'b0, FWD_WB, FWD_RF, 1'b0, 1'b0);
        drain();

        // lw $3 ; beq $3,$0 -> two stall cycles (load in E, then load in M)
        lw(5'd3, 5'd0);          step("lb.lw",  1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        beq(5'd3, 5'd0);         step("lb.s1",  1'b1, FWD_RF, FWD_RF, 1'b0, 1'b0);
        step("lb.s2",  1'b1, FWD_RF, FWD_RF, 1'b1, 1'b0);
        step("lb.go",  1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        nop();                   step("lb.nop", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        drain();

        // add $3 ; beq $3,$0 -> one stall cycle, then branch forward from MEM
        rType(5'd3, 5'd1, 5'd2); step("ab.add", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        beq(5'd3, 5'd0);         step("ab.s1",  1'b1, FWD_RF, FWD_RF, 1'b0, 1'b0);
        step("ab.go",  1'b0, FWD_RF, FWD_RF, 1'b1, 1'b0);
        nop();                   step("ab.nop", 1'b0, FWD_WB, FWD_RF, 1'b0, 1'b0);
        drain();

        // Writes to $0 never stall or forward
        rType(5'd0, 5'd1, 5'd2); step("z.add", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        rType(5'd4, 5'd0, 5'd0); step("z.sub", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        nop();                   step("z.e",   1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        drain();
        lw(5'd0, 5'd1);          step("zl.lw",  1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        rType(5'd4, 5'd0, 5'd0); step("zl.use", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        nop();                   step("zl.e",   1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        drain();

        // Reset pulsed during a load-use stall
        lw(5'd2, 5'd0);          step("rs.lw", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        rType(5'd4, 5'd2, 5'd1);
        Reset = 1'b1;            step("rs.stall", 1'b1, FWD_RF, FWD_RF, 1'b0, 1'b0);
        Reset = 1'b0;            step("rs.after", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        nop();                   step("rs.nop",   1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        drain();

        // Repeated lw/beq pairs: 24 stalls, narrow counter saturates at 15
        for (int i = 0; i < 12; i++) begin
            lw(5'd3, 5'd0);  step("sat.lw", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
            beq(5'd3, 5'd0); step("sat.s1", 1'b1, FWD_RF, FWD_RF, 1'b0, 1'b0);
            step("sat.s2", 1'b1, FWD_RF, FWD_RF, 1'b1, 1'b0);
        end
        nop();
        step("sat.end", 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0);
        chk("sat.final", 32'(StallCount), 32'd24);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage MIPS pipeline; sequences the ID/EX pipeline register and its neighbours.
- Keeps its own shadow copy of destination-register and control bits for the EX, MEM and WB stages.
- From that state and the current ID-stage operands it generates stall, flush and forwarding selects.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- CNT_W, 16, width of the stall-cycle counter StallCount.

Ports:
- Clk  input  1  pipeline clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- RsD  input  5  ID-stage instruction [25:21].
- RtD  input  5  ID-stage instruction [20:16].
- RdD  input  5  ID-stage instruction [15:11].
- RegWriteD  input  1  ID-stage control: instruction writes the register file.
- MemtoRegD  input  1  ID-stage control: instruction is a load.
- RegDstD  input  1  ID-stage control: 1 selects Rd as destination, 0 selects Rt.
- BeqD  input  1  ID-stage control: instruction is a beq, resolved in ID.
- StallF  output  1  hold the PC.
- StallD  output  1  hold the IF/ID register.
- FlushE  output  1  clear the ID/EX register (insert bubble).
- ForwardAE  output  2  ALU src A select: 00 = register file, 01 = WB result, 10 = MEM ALU result.
- ForwardBE  output  2  ALU src B select, same encoding as ForwardAE.
- ForwardAD  output  1  beq comparator A takes the MEM ALU result.
- ForwardBD  output  1  beq comparator B takes the MEM ALU result.
- StallCount  output  CNT_W  number of cycles in which StallD was asserted.

Behaviour:
- WriteRegD = RegDstD ? RdD : RtD (combinational).
- Shadow state, one set per stage:
  - E stage: RsE, RtE, WriteRegE, RegWriteE, MemtoRegE.
  - M stage: WriteRegM, RegWriteM, MemtoRegM.
  - W stage: WriteRegW, RegWriteW.
- Every rising Clk edge:
  - W <= M and M <= E.
  - E <= D values (RsD, RtD, WriteRegD, RegWriteD, MemtoRegD), unless FlushE = 1; then every E field <= 0.
- Reset = 1 at a rising edge: all shadow fields <= 0 and StallCount <= 0, overriding a flush in the same cycle.
- After reset, with no new hazard, all outputs read 0.
- Register 0 never matches any comparison below (a source or destination equal to 0 is ignored).
- lwstall = MemtoRegE & (RtE == RsD | RtE == RtD).
- branchstall = BeqD & ((RegWriteE & (WriteRegE == RsD | WriteRegE == RtD)) | (MemtoRegM & (WriteRegM == RsD | WriteRegM == RtD))).
- StallF = StallD = FlushE = lwstall | branchstall. These are combinational from the current shadow state and D inputs, with zero-cycle latency.
- ForwardAE:
  - 10 if RegWriteM & WriteRegM == RsE;
  - else 01 if RegWriteW & WriteRegW == RsE;
  - else 00.
  - When M and W both match, MEM has priority.
- ForwardBE: same rules as ForwardAE, using RtE.
- ForwardAD = RegWriteM & WriteRegM == RsD; ForwardBD = RegWriteM & WriteRegM == RtD.
- Latency of stalls:
  - A load-use stall lasts exactly 1 cycle; the load moves to M and lwstall drops.
  - A beq depending on an ALU result in E stalls 1 cycle.
  - A beq depending on a load in E stalls 2 cycles: E match, then MemtoRegM match.
- StallCount increments by 1 at each rising edge where StallD = 1 and Reset = 0. It saturates at all-ones and does not wrap.
- lwstall and branchstall may both be true in the same cycle; the result is still a single stall cycle per evaluation.

Decomposition:
- Shared package holds:
  - the forwarding-select encoding constants: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - the register-number width REG_W = 5.
- One sub-module is natural: hazard_shadow_pipe, the E/M/W shadow register chain with flush and reset.
- The top level keeps the comparators, the stall/forward logic and the counter.

Test Plan:
- Reset held 2 cycles, then released with D inputs idle -> all outputs 0, StallCount = 0.
- add $3,$1,$2 followed by sub $4,$3,$5 -> next cycle ForwardAE = 10. Insert one nop between them -> ForwardAE = 01 instead.
- lw $2,0($0) followed by add $4,$2,$1 -> StallF/StallD/FlushE = 1 for exactly 1 cycle, then ForwardAE = 01. StallCount = 1.
- lw $3 followed by beq $3,$0 -> stall 2 consecutive cycles, then ForwardAD = 0. Add $3 followed by beq -> 1 stall cycle, then ForwardAD = 1.
- Writes to $0 (add $0,$1,$2 followed by sub $4,$0,$0) -> no stall and no forward (all Forward* = 0).
- Force a continuous load-use stall for 70000 cycles with CNT_W = 16 -> StallCount saturates at 16'hFFFF. Pulse Reset during a stall -> shadow state cleared, StallCount = 0, FlushE deasserts the next cycle.
